alu_resp_checker: RTL
=====================

ALU_RESP_CHECKER -- requirements
Module: alu_resp_checker

Interface
REQ-001 SHALL have parameter N_TXN, default 8, number of transactions checked per run (1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a run.
REQ-005 SHALL have port in_valid  input  1  transaction present on in_* this cycle.
REQ-006 SHALL have port in_a  input  32  signed operand a.
REQ-007 SHALL have port in_b  input  32  signed operand b.
REQ-008 SHALL have port in_op  input  3  ALU op code.
REQ-009 SHALL have port in_y  input  32  ALU result to check.
REQ-010 SHALL have port busy  output  1  run in progress.
REQ-011 SHALL have port done  output  1  run complete, held until the next start or rst.
REQ-012 SHALL have port pass  output  1  valid with done; 1 when err_cnt is 0.
REQ-013 SHALL have port txn_cnt  output  8  transactions accepted this run.
REQ-014 SHALL have port err_cnt  output  8  mismatches this run, saturating at 255.
REQ-015 SHALL have port first_err_op  output  3  op of the first mismatch.
REQ-016 SHALL have port first_err_y  output  32  in_y of the first mismatch.
REQ-017 SHALL have port first_err_exp  output  32  expected value of the first mismatch.

Function
REQ-018 SHALL compute the expected result per op: 000 a+b; 001 a-b; 010 a&b; 011 a|b; 100 ~a; 101 signed(a<b) zero-extended to 32 bits; 110 and 111 give 0. Add and subtract wrap modulo 2^32.
REQ-019 SHALL use FSM states IDLE, RUN, DRAIN, DONE.
REQ-020 SHALL make these transitions: IDLE->RUN on start; RUN->DRAIN when the N_TXN-th transaction is accepted; DRAIN->DONE once the compare pipeline is empty; DONE->RUN on start.
REQ-021 SHALL, on the entry into RUN, clear txn_cnt, err_cnt, first_err_* and the first-error flag in the same cycle.
REQ-022 SHALL accept a transaction only in RUN with in_valid=1; in_valid is ignored in IDLE, DRAIN and DONE, and transactions beyond N_TXN are dropped.
REQ-023 SHALL use two pipeline stages. Stage 1 registers the inputs and the expected value. Stage 2 compares them and updates err_cnt and first_err_*. err_cnt reflects a transaction 2 cycles after its acceptance.
REQ-024 SHALL increment txn_cnt in the cycle after acceptance.
REQ-025 SHALL capture first_err_* only for the first mismatch of a run; later mismatches only increment err_cnt.
REQ-026 SHALL assert busy in RUN and DRAIN, and assert done only in DONE; pass = done & (err_cnt==0).
REQ-027 SHALL ignore start in RUN and DRAIN.
REQ-028 SHALL, when start and in_valid are both high in IDLE or DONE, not accept the transaction in that cycle.
REQ-029 SHALL, for N_TXN=1, go RUN->DRAIN on the first acceptance.

Reset
REQ-030 SHALL, on rst, go to IDLE and zero all outputs and pipeline valid bits on the next edge; rst has priority over start.
REQ-031 SHALL, on rst mid-run, discard all in-flight pipeline results.

Structure
REQ-032 SHALL take op code constants (OP_ADD..OP_SLT) and FSM state encodings from a shared package, alu_pkg, so the ALU and the checker use one definition.
REQ-033 SHALL compute the expected value in one sub-module, alu_ref_model: combinational, with inputs a, b, op and output exp.

Verification
REQ-034 SHALL verify: N_TXN=8, a=1, b=-1, ops 000..111, in_y from a correct ALU -> done, pass=1, err_cnt=0, txn_cnt=8.
REQ-035 SHALL verify: same stimulus with in_y for op 011 forced to 32'h0 (expected FFFFFFFF) -> err_cnt=1, first_err_op=011, first_err_y=0, first_err_exp=FFFFFFFF, pass=0.
REQ-036 SHALL verify: a=32'h7FFFFFFF, b=1, op=000, in_y=32'h80000000 -> no error (wraps); op=101, a=-1, b=0, in_y=1 -> no error.
REQ-037 SHALL verify: in_valid gapped, 1 cycle on and 1 cycle off -> txn_cnt reaches 8, done 2 cycles after the last accept, and extra valids in DRAIN are not counted.
REQ-038 SHALL verify: rst pulsed after 4 accepts -> all outputs 0 and IDLE next cycle; a fresh start then runs cleanly to pass=1.
REQ-039 SHALL verify: two mismatches (ops 000 and 010) -> first_err_op=000 retained and err_cnt=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, checker FSM encoding and the stage-1 record.
// The ALU and its response checker both import this package.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NOT  = 3'b100,
    OP_SLT  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // One accepted transaction waiting for comparison in stage 2.
  typedef struct packed {
    logic              valid;
    alu_op_e           op;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] exp;
  } stage1_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: the result a correct ALU must produce for (a, b, op).
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] exp
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives exp; otherwise a latch is inferred.
    exp = '0;
    case (alu_op_e'(op))
      OP_ADD:  exp = a + b;
      OP_SUB:  exp = a - b;
      OP_AND:  exp = a & b;
      OP_OR:   exp = a | b;
      OP_NOT:  exp = ~a;
      OP_SLT:  exp = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: exp = '0;
    endcase
  end

endmodule

// File: rtl/alu_resp_checker.sv
// Scores N_TXN ALU responses per run against alu_ref_model through a two-stage
// pipeline, keeping an error count and the first mismatch seen.
module alu_resp_checker
  import alu_pkg::*;
#(
  parameter int unsigned N_TXN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [2:0]        first_err_op,
  output logic [DATA_W-1:0] first_err_y,
  output logic [DATA_W-1:0] first_err_exp
);

  localparam logic [CNT_W-1:0] TXN_TOTAL = CNT_W'(N_TXN);
  localparam logic [CNT_W-1:0] TXN_LAST  = CNT_W'(N_TXN - 1);

  chk_state_e        state_q, state_d;
  stage1_t           s1_q;
  logic [DATA_W-1:0] exp_w;
  logic              accept;
  logic              last_accept;
  logic              run_entry;
  logic              s2_mismatch;
  logic              first_err_seen_q;
  logic [CNT_W-1:0]  txn_cnt_q, err_cnt_q;
  logic [2:0]        first_err_op_q;
  logic [DATA_W-1:0] first_err_y_q, first_err_exp_q;

  alu_ref_model u_ref (
    .a   (in_a),
    .b   (in_b),
    .op  (in_op),
    .exp (exp_w)
  );

  // Only RUN takes transactions, which also covers start+in_valid in IDLE/DONE.
  assign accept      = (state_q == RUN) && in_valid && (txn_cnt_q < TXN_TOTAL);
  assign last_accept = accept && (txn_cnt_q == TXN_LAST);
  assign s2_mismatch = s1_q.valid && (s1_q.y != s1_q.exp);

  always_comb begin
    state_d   = state_q;
    run_entry = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          run_entry = 1'b1;
        end
      end
      RUN: begin
        if (last_accept) state_d = DRAIN;
      end
      // The last transaction sits in stage 1 during DRAIN and is scored on the
      // same edge that enters DONE, so the pipeline is empty once DONE is seen.
      DRAIN: state_d = DONE;
      DONE: begin
        if (start) begin
          state_d   = RUN;
          run_entry = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      s1_q             <= '0;
      txn_cnt_q        <= '0;
      err_cnt_q        <= '0;
      first_err_seen_q <= 1'b0;
      first_err_op_q   <= '0;
      first_err_y_q    <= '0;
      first_err_exp_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;

      s1_q.valid <= accept;
      s1_q.op    <= alu_op_e'(in_op);
      s1_q.y     <= in_y;
      s1_q.exp   <= exp_w;

      if (run_entry) begin
        txn_cnt_q        <= '0;
        err_cnt_q        <= '0;
        first_err_seen_q <= 1'b0;
        first_err_op_q   <= '0;
        first_err_y_q    <= '0;
        first_err_exp_q  <= '0;
      end else begin
        if (accept) txn_cnt_q <= txn_cnt_q + 1'b1;
        if (s2_mismatch) begin
          err_cnt_q <= sat_inc(err_cnt_q);
          if (!first_err_seen_q) begin
            first_err_seen_q <= 1'b1;
            first_err_op_q   <= s1_q.op;
            first_err_y_q    <= s1_q.y;
            first_err_exp_q  <= s1_q.exp;
          end
        end
      end
    end
  end

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign pass          = done && (err_cnt_q == '0);
  assign txn_cnt       = txn_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_op  = first_err_op_q;
  assign first_err_y   = first_err_y_q;
  assign first_err_exp = first_err_exp_q;

endmodule
